alu_seq_exec: RTL

//  Execute-stage ALU that consumes the 4-bit ALU control code from the ALU controller.

---
 rtl/alu_pkg.sv | 19 +
 rtl/mul_seq.sv | 44 ++++
 rtl/alu_seq_exec.sv | 112 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control encoding and execute-stage FSM states.
// The ALU controller imports this too, so both ends agree on the codes.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_MULT = 4'd3;
  localparam logic [3:0] ALU_LUI  = 4'd4;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_seq.sv
// Iterative shift-add multiplier datapath: one partial product per step.
// product_o is what the accumulator holds after the current step.
module mul_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] product_o,
  output logic             last_o
);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;

  assign product_o = b_q[0] ? (acc_q + a_q) : acc_q;
  assign last_o    = step_i && (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (step_i) begin
      acc_q <= product_o;
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq_exec.sv
// Execute-stage ALU: single-cycle logic/arith ops plus a multi-cycle multiply
// with a start/busy/done handshake so the control unit can stall the pipeline.
module alu_seq_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ctrl_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           state_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] diff;
  logic             slt_bit;
  logic [WIDTH-1:0] mul_prod;
  logic             mul_last;
  logic             mul_load;

  assign diff    = src1_i - src2_i;
  // Signed less-than: sign of the difference, corrected when the subtraction overflowed.
  assign slt_bit = diff[WIDTH-1] ^
                   ((src1_i[WIDTH-1] ^ src2_i[WIDTH-1]) & (diff[WIDTH-1] ^ src1_i[WIDTH-1]));

  always_comb begin
    result_d = '0;
    case (ctrl_i)
      ALU_AND: result_d = src1_i & src2_i;
      ALU_OR:  result_d = src1_i | src2_i;
      ALU_ADD: result_d = src1_i + src2_i;
      ALU_SUB: result_d = diff;
      ALU_SLT: result_d = {{(WIDTH-1){1'b0}}, slt_bit};
      ALU_LUI: result_d = {src2_i[15:0], {(WIDTH-16){1'b0}}};
      default: result_d = '0;
    endcase
  end

  assign mul_load = start_i && (ctrl_i == ALU_MULT) && (state_q != ST_MUL);

  mul_seq #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_mul (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (mul_load),
    .step_i   (state_q == ST_MUL),
    .a_i      (src1_i),
    .b_i      (src2_i),
    .product_o(mul_prod),
    .last_o   (mul_last)
  );

  // IDLE and DONE both accept a new start, which gives back-to-back issue.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_MUL: begin
          if (mul_last) begin
            result_q <= mul_prod;
            zero_q   <= (mul_prod == '0);
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
          if (start_i) begin
            if (ctrl_i == ALU_MULT) begin
              busy_q  <= 1'b1;
              state_q <= ST_MUL;
            end else begin
              result_q <= result_d;
              zero_q   <= (result_d == '0);
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end
          end
        end
      endcase
    end
  end

  assign result_o = result_q;
  assign zero_o   = zero_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule
